fifo_width_down_converter: RTL

Parametrised FIFO that accepts IN_WIDTH-bit words and delivers them as OUT_WIDTH-bit lanes. It adds four things: a generic width ratio, selectable lane order, partial (short) words, and level/almost-full/error status. It sits between word-oriented producers (debug/register dump logic) and byte-oriented consumers (the UART transmitter). It drives show-ahead data: the current lane is always presented on o_rd_data, and i_rd consumes it.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_lane_mux.sv | 30 +++
 rtl/fifo_width_down_converter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the width down-converting FIFO: lane-order constants and a
// constant-foldable clog2 used to size lane indices.
package fifo_pkg;

    localparam int unsigned LANE_LSB_FIRST = 0;
    localparam int unsigned LANE_MSB_FIRST = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_lane_mux.sv
// RATIO:1 combinational lane selector; lane 0 is either the lowest or the highest
// OUT_WIDTH bits of the word depending on MSB_FIRST.
module fifo_lane_mux
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned MSB_FIRST = LANE_LSB_FIRST,
    parameter int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int unsigned LW        = clog2(IN_WIDTH / OUT_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [LW-1:0]        i_lane,
    output logic [OUT_WIDTH-1:0] o_lane
);

    always_comb begin
        o_lane = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (i_lane == LW'(i)) begin
                if (MSB_FIRST == LANE_MSB_FIRST) begin
                    o_lane = i_data[(int'(RATIO) - 1 - i) * int'(OUT_WIDTH) +: OUT_WIDTH];
                end else begin
                    o_lane = i_data[i * int'(OUT_WIDTH) +: OUT_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_width_down_converter.sv
// Word-in, lane-out show-ahead FIFO with per-word last-lane index, selectable lane order
// and count-derived status flags.
module fifo_width_down_converter
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MSB_FIRST  = LANE_LSB_FIRST,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 2
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_wr,
    input  logic [IN_WIDTH-1:0]                      i_wr_data,
    input  logic [clog2(IN_WIDTH / OUT_WIDTH)-1:0]   i_wr_last,
    input  logic                                     i_rd,
    output logic [OUT_WIDTH-1:0]                     o_rd_data,
    output logic                                     o_rd_last,
    output logic                                     o_empty,
    output logic                                     o_full,
    output logic                                     o_almost_full,
    output logic [ADDR_WIDTH:0]                      o_level,
    output logic                                     o_wr_err,
    output logic                                     o_rd_err
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned LW    = clog2(RATIO);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned EW    = LW + IN_WIDTH;

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
        $error("IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("IN_WIDTH/OUT_WIDTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("AF_LEVEL must lie in 1..2**ADDR_WIDTH");
    end

    logic [EW-1:0]         r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_lane;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic [EW-1:0]         w_entry;
    logic [LW-1:0]         w_last;
    logic [IN_WIDTH-1:0]   w_data;
    logic [OUT_WIDTH-1:0]  w_lane_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_pop;

    assign w_full   = (r_count == (ADDR_WIDTH + 1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = i_wr && !w_full;
    assign w_rd_acc = i_rd && !w_empty;

    assign w_entry  = r_mem[r_rd_ptr];
    assign w_last   = w_entry[EW-1 -: LW];
    assign w_data   = w_entry[IN_WIDTH-1:0];
    assign w_pop    = w_rd_acc && (r_lane == w_last);

    // Storage is deliberately not reset; the count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {i_wr_last, i_wr_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lane   <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                if (w_pop) begin
                    r_lane   <= '0;
                    r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                end else begin
                    r_lane <= r_lane + LW'(1);
                end
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
            r_wr_err <= i_wr && w_full;
            r_rd_err <= i_rd && w_empty;
        end
    end

    fifo_lane_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .RATIO     (RATIO),
        .LW        (LW)
    ) u_lane_mux (
        .i_data (w_data),
        .i_lane (r_lane),
        .o_lane (w_lane_data)
    );

    assign o_rd_data     = w_empty ? '0 : w_lane_data;
    assign o_rd_last     = !w_empty && (r_lane == w_last);
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_almost_full = (r_count >= (ADDR_WIDTH + 1)'(AF_LEVEL));
    assign o_level       = r_count;
    assign o_wr_err      = r_wr_err;
    assign o_rd_err      = r_rd_err;

endmodule
